isa_imem_writer: RTL and testbench
==================================

# isa_imem_writer

Consumes the 128-bit instruction words produced by the 64-to-128 ISA width converter and writes them into the CPU instruction memory. It buffers words in a small FIFO, converts byte addresses to memory word addresses and tolerates memory back-pressure. It tracks progress against a programmed load length and raises a done flag.

## Interface

Parameters:
- DATA_W, 128, instruction word width
- ADDR_W, 32, incoming byte-address width
- IMEM_AW, 10, instruction-memory word-address width
- FIFO_DEPTH, 4, buffer entries (power of two, ≥2)

Ports:
- clk_cpu  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- isa_data_i  in  DATA_W  instruction word
- isa_wren_i  in  1  one-cycle strobe; data and address are valid in the strobe cycle
- isa_addr_i  in  ADDR_W  byte address of the word, 16-byte aligned
- isa_full_o  out  1  FIFO holds FIFO_DEPTH entries
- load_start_i  in  1  one-cycle pulse that arms a new load
- load_len_i  in  16  expected word count, sampled on load_start_i
- imem_we_o  out  1  memory write request
- imem_addr_o  out  IMEM_AW  word address, equal to isa_addr_i[IMEM_AW+3:4]
- imem_wdata_o  out  DATA_W  write data
- imem_busy_i  in  1  memory stall; a write is not taken while this is high
- load_done_o  out  1  level; the programmed count has been written
- words_o  out  16  number of words written in the current load
- err_ovf_o  out  1  sticky; a strobe was dropped because the FIFO was full
- err_align_o  out  1  sticky; a strobe was dropped because its address was misaligned

## Operation

- States: IDLE, LOAD, DONE. Reset puts the block in IDLE.
- load_start_i has priority in every state. On load_start_i:
  - flush the FIFO, clear words_o, err_ovf_o and err_align_o
  - latch load_len_i
  - go to LOAD; if load_len_i is 0, go to DONE instead
- IDLE and DONE: isa_wren_i is ignored. No enqueue, no flag is set.
- LOAD, enqueue: on isa_wren_i, push {addr, data} unless the strobe is dropped.
  - If isa_addr_i[3:0] ≠ 0: drop the strobe and set err_align_o.
  - Else if the FIFO is full: drop the strobe and set err_ovf_o.
- Full is tested on the registered count. A push in the same cycle as a pop is still refused when the count equals FIFO_DEPTH.
- LOAD, drain:
  - imem_we_o = FIFO not empty; imem_addr_o and imem_wdata_o show the FIFO head.
  - A write completes in a cycle where imem_we_o=1 and imem_busy_i=0. On completion: pop the head and increment words_o.
- When a completion brings words_o to the latched length, go to DONE.
  - Entering DONE flushes the FIFO, discarding excess words.
  - load_done_o=1 while in DONE.
- While imem_busy_i=1, imem_addr_o and imem_wdata_o stay stable.
- Address bits above IMEM_AW+3 are ignored. The block does not check them.
- words_o saturates at 0xFFFF.

## Timing

- Reset values:
  - state IDLE, FIFO empty
  - imem_we_o, load_done_o, err_ovf_o, err_align_o and isa_full_o are 0
  - words_o, imem_addr_o and imem_wdata_o are 0
- Latency: a strobe in cycle N into an empty FIFO with imem_busy_i=0 gives imem_we_o=1 in cycle N+1. The completion is at the end of N+1.
- Throughput: one word per cycle when there is no stall.
- isa_full_o is combinational from the registered count. It rises in the cycle after the FIFO_DEPTH-th push.
- load_done_o rises in the cycle after the final completion. It falls in the cycle after load_start_i.
- load_start_i with load_len_i=0 gives load_done_o=1 in the next cycle.
- rst asserted at any point, including mid-write: all state and outputs clear immediately; any pending FIFO data is lost.

## Test plan

- Nominal load:
  - Stimulus: load_start_i with len 3, then strobes to 0x000, 0x010, 0x020 on consecutive cycles, busy=0.
  - Response: imem_we_o high for 3 cycles with addresses 0, 1, 2; words_o=3; load_done_o=1 one cycle later.
- Stall:
  - Stimulus: len 2, two strobes, imem_busy_i held high for 3 cycles.
  - Response: imem_addr_o and imem_wdata_o are stable and words_o=0 through the stall. Both writes complete after busy drops. Done follows.
- Overflow:
  - Stimulus: busy=1, len 8, 5 back-to-back strobes.
  - Response: 4 entries are queued; isa_full_o=1; the 5th is dropped; err_ovf_o=1. After busy falls, exactly 4 writes occur.
- Misalignment:
  - Stimulus: a strobe to 0x018.
  - Response: err_align_o=1, no imem write, words_o is unchanged.
- Zero length and rearm:
  - Stimulus: load_start_i with len 0.
  - Response: load_done_o=1 next cycle.
  - Stimulus: a second load_start_i with len 1.
  - Response: load_done_o=0 and the flags are cleared.
- Reset mid-load:
  - Stimulus: rst asserted while 2 entries are queued and busy=1.
  - Response: all outputs are 0 asynchronously; after release, no writes occur until the next load_start_i.

Source files
------------

// File: rtl/isa_imem_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : isa_imem_writer_if
// Brief    : ISA word stream, load control and instruction-memory write bus
// Revision : 1.0
// ============================================================================
interface isa_imem_writer_if #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 32,
    parameter int IMEM_AW = 10
);
    logic [DATA_W-1:0]  isa_data_i;
    logic               isa_wren_i;
    logic [ADDR_W-1:0]  isa_addr_i;
    logic               isa_full_o;
    logic               load_start_i;
    logic [15:0]        load_len_i;
    logic               imem_we_o;
    logic [IMEM_AW-1:0] imem_addr_o;
    logic [DATA_W-1:0]  imem_wdata_o;
    logic               imem_busy_i;
    logic               load_done_o;
    logic [15:0]        words_o;
    logic               err_ovf_o;
    logic               err_align_o;

    modport slave (
        input  isa_data_i, isa_wren_i, isa_addr_i, load_start_i, load_len_i, imem_busy_i,
        output isa_full_o, imem_we_o, imem_addr_o, imem_wdata_o, load_done_o, words_o,
               err_ovf_o, err_align_o
    );

    modport master (
        output isa_data_i, isa_wren_i, isa_addr_i, load_start_i, load_len_i, imem_busy_i,
        input  isa_full_o, imem_we_o, imem_addr_o, imem_wdata_o, load_done_o, words_o,
               err_ovf_o, err_align_o
    );
endinterface
`default_nettype wire

// File: rtl/isa_imem_writer.sv
`default_nettype none
// ============================================================================
// Module   : isa_imem_writer
// Brief    : Buffers ISA words in a FIFO and writes them to instruction memory
// Revision : 1.0
// ============================================================================
module isa_imem_writer #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 32,
    parameter int IMEM_AW    = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic        clk_cpu,
    input  wire logic        rst,
    isa_imem_writer_if.slave bus
);
    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IMEM_AW-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic [15:0]        r_len;
    logic [15:0]        r_words;
    logic               r_err_ovf;
    logic               r_err_align;

    logic [ADDR_W-1:0]  w_addr;
    logic               w_empty;
    logic               w_full;
    logic               w_strobe;
    logic               w_misalign;
    logic               w_ovf;
    logic               w_push;
    logic               w_pop;
    logic [15:0]        w_words_inc;
    logic               w_last;
    logic               w_flush;

    assign w_addr = bus.isa_addr_i;

    generate
        if (ADDR_W > IMEM_AW + 4) begin : g_unused_hi
            wire logic w_unused_addr_hi = &{1'b0, w_addr[ADDR_W-1:IMEM_AW+4]};
        end
    endgenerate

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_DEPTH);
    assign w_strobe    = (r_state == S_LOAD) && bus.isa_wren_i;
    assign w_misalign  = w_strobe && (w_addr[3:0] != 4'd0);
    assign w_ovf       = w_strobe && (w_addr[3:0] == 4'd0) && w_full;
    assign w_push      = w_strobe && (w_addr[3:0] == 4'd0) && !w_full;
    assign w_pop       = (r_state == S_LOAD) && !w_empty && !bus.imem_busy_i;
    assign w_words_inc = (r_words == 16'hFFFF) ? r_words : r_words + 16'd1;
    assign w_last      = w_pop && (w_words_inc == r_len);

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new load always wins; reaching the count drops whatever is still queued.
    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        if (bus.load_start_i) begin
            w_flush     = 1'b1;
            w_state_nxt = (bus.load_len_i == 16'd0) ? S_DONE : S_LOAD;
        end else if ((r_state == S_LOAD) && w_last) begin
            w_flush     = 1'b1;
            w_state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_len       <= '0;
            r_words     <= '0;
            r_err_ovf   <= 1'b0;
            r_err_align <= 1'b0;
        end else begin
            if (bus.load_start_i) begin
                r_len       <= bus.load_len_i;
                r_words     <= '0;
                r_err_ovf   <= 1'b0;
                r_err_align <= 1'b0;
            end else begin
                if (w_pop)      r_words     <= w_words_inc;
                if (w_ovf)      r_err_ovf   <= 1'b1;
                if (w_misalign) r_err_align <= 1'b1;
            end

            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
                if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                    2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: the read side is masked whenever the FIFO is empty.
    always_ff @(posedge clk_cpu) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= w_addr[IMEM_AW+3:4];
            r_fifo_data[r_wptr] <= bus.isa_data_i;
        end
    end

    assign bus.imem_we_o    = (r_state == S_LOAD) && !w_empty;
    assign bus.imem_addr_o  = bus.imem_we_o ? r_fifo_addr[r_rptr] : '0;
    assign bus.imem_wdata_o = bus.imem_we_o ? r_fifo_data[r_rptr] : '0;
    assign bus.isa_full_o   = w_full;
    assign bus.load_done_o  = (r_state == S_DONE);
    assign bus.words_o      = r_words;
    assign bus.err_ovf_o    = r_err_ovf;
    assign bus.err_align_o  = r_err_align;

endmodule
`default_nettype wire

// File: tb/tb_isa_imem_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_isa_imem_writer
// Brief    : Directed scoreboard bench for isa_imem_writer
// Revision : 1.0
// ============================================================================
module tb_isa_imem_writer;
    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 32;
    localparam int IMEM_AW    = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int ENT_W      = IMEM_AW + DATA_W;

    logic clk_cpu = 1'b0;
    logic rst     = 1'b1;

    isa_imem_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMEM_AW(IMEM_AW)) bus ();

    isa_imem_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMEM_AW(IMEM_AW), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_cpu (clk_cpu),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #5 clk_cpu = ~clk_cpu;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [ENT_W-1:0] sb_q[$];
    logic [ENT_W:0]   mon_exp;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every accepted memory write must match the oldest expected entry.
    always @(negedge clk_cpu) begin
        if (!rst && bus.imem_we_o === 1'b1 && bus.imem_busy_i === 1'b0) begin
            if (sb_q.size() == 0) mon_exp = '0;
            else                  mon_exp = {1'b1, sb_q.pop_front()};
            chk("write", {1'b1, bus.imem_addr_o, bus.imem_wdata_o}, mon_exp);
        end
    end

    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic start(input logic [15:0] len);
        bus.load_start_i = 1'b1;
        bus.load_len_i   = len;
        tick();
        bus.load_start_i = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] addr, input logic accept);
        logic [127:0] d;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.isa_wren_i = 1'b1;
        bus.isa_addr_i = addr;
        bus.isa_data_i = d;
        if (accept) sb_q.push_back({addr[IMEM_AW+3:4], d});
        tick();
        bus.isa_wren_i = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, sb_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    bus.imem_we_o,    0);
        chk({tag, "_addr"},  bus.imem_addr_o,  0);
        chk({tag, "_wdata"}, bus.imem_wdata_o, 0);
        chk({tag, "_words"}, bus.words_o,      0);
        chk({tag, "_done"},  bus.load_done_o,  0);
        chk({tag, "_full"},  bus.isa_full_o,   0);
        chk({tag, "_ovf"},   bus.err_ovf_o,    0);
        chk({tag, "_align"}, bus.err_align_o,  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.isa_data_i   = '0;
        bus.isa_wren_i   = 1'b0;
        bus.isa_addr_i   = '0;
        bus.load_start_i = 1'b0;
        bus.load_len_i   = '0;
        bus.imem_busy_i  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_cpu);
        #1;
        chk_all_zero("rst");
        rst = 1'b0;
        tick();

        // Strobes before any load are ignored
        strobe(32'h0, 1'b0);
        chk("idle_we", bus.imem_we_o, 0);

        // Nominal load of three words
        start(16'd3);
        chk("nom_done0", bus.load_done_o, 0);
        strobe(32'h000, 1'b1);
        chk("nom_we", bus.imem_we_o, 1);
        strobe(32'h010, 1'b1);
        strobe(32'h020, 1'b1);
        chk("nom_words2", bus.words_o, 2);
        chk("nom_done_early", bus.load_done_o, 0);
        tick();
        chk("nom_words3", bus.words_o, 3);
        chk("nom_done", bus.load_done_o, 1);
        chk("nom_we_off", bus.imem_we_o, 0);

        // Memory stall holds the head stable
        bus.imem_busy_i = 1'b1;
        start(16'd2);
        strobe(32'h100, 1'b1);
        strobe(32'h110, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_head", {bus.imem_addr_o, bus.imem_wdata_o}, sb_q[0]);
            chk("stall_words", bus.words_o, 0);
            tick();
        end
        bus.imem_busy_i = 1'b0;
        drain("stall_drain", 10);
        chk("stall_done", bus.load_done_o, 1);
        chk("stall_words2", bus.words_o, 2);

        // Overflow: fifth strobe into a full FIFO is dropped
        bus.imem_busy_i = 1'b1;
        start(16'd8);
        strobe(32'h200, 1'b1);
        strobe(32'h210, 1'b1);
        strobe(32'h220, 1'b1);
        chk("ovf_full3", bus.isa_full_o, 0);
        strobe(32'h230, 1'b1);
        chk("ovf_full4", bus.isa_full_o, 1);
        chk("ovf_err0", bus.err_ovf_o, 0);
        strobe(32'h240, 1'b0);
        chk("ovf_err1", bus.err_ovf_o, 1);
        chk("ovf_full5", bus.isa_full_o, 1);
        bus.imem_busy_i = 1'b0;
        drain("ovf_drain", 10);
        chk("ovf_words", bus.words_o, 4);
        chk("ovf_done", bus.load_done_o, 0);
        chk("ovf_we_off", bus.imem_we_o, 0);

        // Misaligned strobe
        strobe(32'h018, 1'b0);
        chk("align_err", bus.err_align_o, 1);
        chk("align_we", bus.imem_we_o, 0);
        chk("align_words", bus.words_o, 4);
        chk("align_ovf_sticky", bus.err_ovf_o, 1);

        // Zero length, then rearm with one word at a high address
        start(16'd0);
        chk("zero_done", bus.load_done_o, 1);
        chk("zero_words", bus.words_o, 0);
        chk("zero_align_clr", bus.err_align_o, 0);
        chk("zero_ovf_clr", bus.err_ovf_o, 0);
        strobe(32'h0, 1'b0);
        chk("done_ignore_we", bus.imem_we_o, 0);
        start(16'd1);
        chk("rearm_done", bus.load_done_o, 0);
        strobe(32'hABCD_E3F0, 1'b1);
        drain("rearm_drain", 10);
        chk("rearm_done1", bus.load_done_o, 1);
        chk("rearm_words", bus.words_o, 1);

        // Asynchronous reset while entries are queued
        start(16'd4);
        bus.imem_busy_i = 1'b1;
        strobe(32'h300, 1'b1);
        strobe(32'h308, 1'b0);
        strobe(32'h310, 1'b1);
        chk("pre_rst_we", bus.imem_we_o, 1);
        chk("pre_rst_align", bus.err_align_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("arst");
        sb_q.delete();
        tick();
        rst = 1'b0;
        bus.imem_busy_i = 1'b0;
        strobe(32'h400, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_we", bus.imem_we_o, 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
